// File: rtl/rv32_program_loader.sv
// rv32_program_loader: boot-time loader that encodes symbolic RV32I
// instructions (add, sub, and, or, addi, lw, sw, beq) and writes them into
// instruction memory from word 0. The CPU is held in reset until the
// program is resident.
//
// Optional feature macro: LOADER_PAD_EN. When it is defined, every slot
// after the last instruction is filled with NOP (0x00000013) before the
// pipeline is released.
//
// state | meaning
// LOAD  | accepting instructions, one per cycle
// PAD   | filling the remaining slots with NOP (LOADER_PAD_EN only)
// FIN   | last memory write completes; pipeline still held
// DONE  | program resident, pipeline released, inputs ignored
module rv32_program_loader #(
    parameter int IMEM_DEPTH = 64,
    localparam int AW = $clog2(IMEM_DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [12:0]   in_imm,
    input  logic          in_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          err,
    output logic [AW:0]   word_count
);

    localparam logic [31:0]   NOP       = 32'h0000_0013;
    localparam logic [AW-1:0] LAST_SLOT = AW'(IMEM_DEPTH - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
`ifdef LOADER_PAD_EN
        PAD  = 2'd1,
`endif
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic          ready_nxt, we_nxt, hold_nxt, done_nxt, err_nxt;
    logic [AW-1:0] addr_nxt;
    logic [31:0]   wdata_nxt;
    logic [AW:0]   count_nxt;

    logic [31:0]   enc_word;
    logic          enc_ok;
    logic          imm12_ok;
    logic          accept;

    assign accept   = in_valid && in_ready;
    // imm fits in 12 signed bits exactly when bit 12 merely sign-extends bit 11
    assign imm12_ok = (in_imm[12] == in_imm[11]);

    // Encode the presented instruction and flag an out-of-range immediate
    always_comb begin
        enc_word = NOP;
        enc_ok   = 1'b1;
        case (in_op)
            3'd0: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
            3'd1: enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
            3'd2: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, 7'b0110011};
            3'd3: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, 7'b0110011};
            3'd4: begin
                enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
                enc_ok   = imm12_ok;
            end
            3'd5: begin
                enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
                enc_ok   = imm12_ok;
            end
            3'd6: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
                enc_ok   = imm12_ok;
            end
            default: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                            in_imm[4:1], in_imm[11], 7'b1100011};
                // every even 13-bit value lies in [-4096, 4094]
                enc_ok   = ~in_imm[0];
            end
        endcase
    end

    // Next-state and next-output logic; outputs are registered from these
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        we_nxt     = 1'b0;
        addr_nxt   = imem_addr;
        wdata_nxt  = imem_wdata;
        err_nxt    = err;
        count_nxt  = word_count;
        case (state)
            LOAD: begin
                if (accept) begin
                    we_nxt     = 1'b1;
                    addr_nxt   = wr_ptr;
                    wdata_nxt  = enc_ok ? enc_word : NOP;
                    err_nxt    = err | ~enc_ok;
                    wr_ptr_nxt = wr_ptr + AW'(1);
                    count_nxt  = word_count + (AW+1)'(1);
                    if (wr_ptr == LAST_SLOT) begin
                        // memory full: a missing in_last is an overflow
                        if (!in_last) err_nxt = 1'b1;
                        state_nxt = FIN;
                    end else if (in_last) begin
`ifdef LOADER_PAD_EN
                        state_nxt = PAD;
`else
                        state_nxt = FIN;
`endif
                    end
                end
            end
`ifdef LOADER_PAD_EN
            PAD: begin
                we_nxt     = 1'b1;
                addr_nxt   = wr_ptr;
                wdata_nxt  = NOP;
                wr_ptr_nxt = wr_ptr + AW'(1);
                if (wr_ptr == LAST_SLOT) state_nxt = FIN;
            end
`endif
            FIN:     state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = LOAD;
        endcase
        ready_nxt = (state_nxt == LOAD);
        hold_nxt  = (state_nxt != DONE);
        done_nxt  = (state_nxt == DONE);
    end

    // State, write pointer and all outputs, with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            in_ready   <= ready_nxt;
            imem_we    <= we_nxt;
            imem_addr  <= addr_nxt;
            imem_wdata <= wdata_nxt;
            cpu_hold   <= hold_nxt;
            load_done  <= done_nxt;
            err        <= err_nxt;
            word_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_rv32_program_loader.sv
// Directed testbench for rv32_program_loader with an 8-word memory.
// Follows LOADER_PAD_EN so the same bench covers both builds.
module tb_rv32_program_loader;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [12:0]   in_imm = '0;
    logic          in_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold, load_done, err;
    logic [AW:0]   word_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [DEPTH];
    int          n_writes;

    rv32_program_loader #(.IMEM_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done), .err(err),
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    // Memory model: captures the write presented during the previous cycle
    always @(posedge clock) begin
        if (!reset) n_writes <= 0;
        else if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
            n_writes <= n_writes + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        tick();
        check("rst in_ready", in_ready, 0);
        check("rst imem_we", imem_we, 0);
        check("rst imem_addr", imem_addr, 0);
        check("rst imem_wdata", imem_wdata, 0);
        check("rst cpu_hold", cpu_hold, 1);
        check("rst load_done", load_done, 0);
        check("rst err", err, 0);
        check("rst word_count", word_count, 0);
        reset = 1'b1;
        tick();
        check("first in_ready", in_ready, 1);
    endtask

    // Present one instruction for one edge and check the resulting write
    task automatic send(input string tag, input logic [2:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                        input logic last, input int slot, input logic [31:0] exp);
        in_valid = 1'b1;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        tick();
        in_valid = 1'b0;
        check({tag, " we"}, imem_we, 1);
        check({tag, " addr"}, imem_addr, slot);
        check({tag, " wdata"}, imem_wdata, exp);
    endtask

    // After the last accept: optional NOP padding from slot k, then release
    task automatic finish_program(input int k);
`ifdef LOADER_PAD_EN
        for (int i = k; i < DEPTH; i++) begin
            tick();
            check("pad we", imem_we, 1);
            check("pad addr", imem_addr, i);
            check("pad wdata", imem_wdata, NOP);
            check("pad hold", cpu_hold, 1);
            check("pad in_ready", in_ready, 0);
        end
`endif
        check("fin hold", cpu_hold, 1);
        check("fin done", load_done, 0);
        tick();
        check("done we", imem_we, 0);
        check("done hold", cpu_hold, 0);
        check("done load_done", load_done, 1);
        check("done in_ready", in_ready, 0);
    endtask

    initial begin
        // Full program, filling memory exactly, with one range error
        do_reset();
        send("add", 3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 0, 32'h002081B3);
        send("sub", 3'd1, 5'd5, 5'd3, 5'd4, 13'd0, 1'b0, 1, 32'h404182B3);
        send("addi5", 3'd4, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0, 2, 32'h00500093);
        send("addi-1", 3'd4, 5'd2, 5'd0, 5'd0, 13'h1FFF, 1'b0, 3, 32'hFFF00113);
        send("lw", 3'd5, 5'd6, 5'd2, 5'd0, 13'd8, 1'b0, 4, 32'h00812303);
        send("sw", 3'd6, 5'd0, 5'd2, 5'd5, 13'd4, 1'b0, 5, 32'h00512223);
        check("err clean", err, 0);
        send("addi2048", 3'd4, 5'd1, 5'd0, 5'd0, 13'd2048, 1'b0, 6, NOP);
        check("err addi2048", err, 1);
        send("beq", 3'd7, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b1, 7, 32'hFE208CE3);
        check("beq in_ready", in_ready, 0);
        check("beq hold", cpu_hold, 1);
        finish_program(DEPTH);
        in_valid = 1'b1;
        in_op = 3'd0;
        repeat (3) tick();
        in_valid = 1'b0;
        check("A count", word_count, 8);
        check("A err sticky", err, 1);
        check("A done kept", load_done, 1);
        check("A we idle", imem_we, 0);
        check("A wdata held", imem_wdata, 32'hFE208CE3);
        check("A writes", n_writes, 8);
        check("A mem0", mem[0], 32'h002081B3);
        check("A mem4", mem[4], 32'h00812303);
        check("A mem6", mem[6], NOP);
        check("A mem7", mem[7], 32'hFE208CE3);

        // Odd branch offset, then a short program
        do_reset();
        send("beq3", 3'd7, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0, 0, NOP);
        check("err beq3", err, 1);
        send("add last", 3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 1, 32'h002081B3);
        finish_program(2);
        check("B err", err, 1);
        check("B count", word_count, 2);
        check("B mem0", mem[0], NOP);
        check("B mem1", mem[1], 32'h002081B3);
`ifdef LOADER_PAD_EN
        check("B writes", n_writes, 8);
        check("B mem7", mem[7], NOP);
`else
        check("B writes", n_writes, 2);
`endif

        // Immediate boundaries, and/or, range error on the last instruction
        do_reset();
        send("lw-2048", 3'd5, 5'd6, 5'd2, 5'd0, 13'h1800, 1'b0, 0, 32'h80012303);
        send("beq-4096", 3'd7, 5'd0, 5'd1, 5'd2, 13'h1000, 1'b0, 1, 32'h80208063);
        send("and", 3'd2, 5'd7, 5'd8, 5'd9, 13'd0, 1'b0, 2, 32'h009473B3);
        send("or", 3'd3, 5'd10, 5'd11, 5'd12, 13'd0, 1'b0, 3, 32'h00C5E533);
        check("C err clean", err, 0);
        send("addi-2049", 3'd4, 5'd1, 5'd0, 5'd0, 13'h17FF, 1'b1, 4, NOP);
        check("C err", err, 1);
        finish_program(5);
        check("C count", word_count, 5);

        // Reset mid-load (mid-padding when padding is built in), then reload
        do_reset();
        send("D add", 3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 0, 32'h002081B3);
`ifdef LOADER_PAD_EN
        send("D sub", 3'd1, 5'd5, 5'd3, 5'd4, 13'd0, 1'b1, 1, 32'h404182B3);
`else
        send("D sub", 3'd1, 5'd5, 5'd3, 5'd4, 13'd0, 1'b0, 1, 32'h404182B3);
`endif
        tick();
        tick();
        do_reset();
        send("D reload", 3'd3, 5'd10, 5'd11, 5'd12, 13'd0, 1'b0, 0, 32'h00C5E533);
        check("D count", word_count, 1);

        // Overflow: eight words without in_last, valid held afterwards
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            send("ovf", 3'd4, 5'd1, 5'd0, 5'd0, 13'(i), 1'b0, i, {20'd0, 12'(i), 5'd0, 3'b000, 5'd1, 7'b0010011} ^ 32'h0000_0093 ^ 32'h0000_0093);
        check("ovf in_ready", in_ready, 0);
        check("ovf err", err, 1);
        check("ovf count", word_count, 8);
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        check("ovf count held", word_count, 8);
        check("ovf writes", n_writes, 8);
        check("ovf done", load_done, 1);
        check("ovf mem7", mem[7], 32'h00700093);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_program_loader.md
# rv32_program_loader

Boot-time program loader for the 5-stage RV32 pipeline, the inverse of the pipeline trace disassembler. It accepts symbolic instructions (operation, register fields, immediate) over a valid/ready stream and encodes each one into a 32-bit RV32I word. It writes the words sequentially into instruction memory from word 0 and holds the CPU in reset until loading completes. The supported subset is exactly add, sub, and, or, addi, lw, sw and beq.

## Interface
- IMEM_DEPTH, 64, instruction memory depth in 32-bit words; power of two, ≥2. AW = $clog2(IMEM_DEPTH).
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- in_valid  in  1  source has an instruction.
- in_ready  out  1  loader accepts this cycle.
- in_op  in  3  0 add, 1 sub, 2 and, 3 or, 4 addi, 5 lw, 6 sw, 7 beq.
- in_rd, in_rs1, in_rs2  in  5 each  register indices; unused fields are ignored.
- in_imm  in  13  signed immediate (byte offset for beq).
- in_last  in  1  marks the final instruction of the program.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  AW  word index (byte address = 4*imem_addr).
- imem_wdata  out  32  encoded word.
- cpu_hold  out  1  keeps the pipeline in reset while high.
- load_done  out  1  program resident, pipeline released.
- err  out  1  sticky error flag.
- word_count  out  AW+1  number of instructions accepted.

## Operation
- FSM states: LOAD, PAD, FIN, DONE. Reset enters LOAD.
- LOAD:
  - in_ready=1.
  - Accept = in_valid && in_ready. On each accept, register the encoded word at wr_ptr, then wr_ptr++ and word_count++.
- Encodings (opcode, funct3):
  - R-type 0110011, funct3: add/sub 000, and 111, or 110. funct7 is 0100000 for sub, otherwise 0.
  - addi: 0010011, funct3 000, imm[11:0].
  - lw: 0000011, funct3 010.
  - sw: 0100011, funct3 010, {imm[11:5], rs2, rs1, 010, imm[4:0]}.
  - beq: 1100011, funct3 000, {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11]}.
- Range checks:
  - addi/lw/sw: imm must lie in [-2048, 2047].
  - beq: imm must lie in [-4096, 4094] and be even.
  - On a violation, write the NOP 0x00000013 in that slot and set err. Loading continues.
- Leaving LOAD:
  - Accept with in_last=1: go to PAD if padding is enabled and slots remain, otherwise go to FIN.
  - Accept into slot IMEM_DEPTH-1 with in_last=0: set err (overflow) and go to FIN. This acceptance is treated as the last instruction.
- PAD: no accepts. Each cycle writes 0x00000013 at wr_ptr and increments wr_ptr. After issuing the write for slot IMEM_DEPTH-1, go to FIN.
- FIN: one cycle. The final write completes during it. imem_we=0, cpu_hold=1.
- DONE: terminal until reset.
  - cpu_hold=0, load_done=1, in_ready=0.
  - in_valid is ignored.
  - err and word_count are frozen.

## Timing
- All outputs are registered. Reset values:
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, load_done=0, err=0, word_count=0.
- First cycle after reset deasserts: in_ready=1.
- Accept at edge N:
  - imem_we/addr/wdata are valid from N to N+1; memory captures at edge N+1.
  - Latency is 1 cycle.
  - Throughput is 1 instruction per cycle; back-to-back accepts need no gaps.
- Last accept at edge N without padding:
  - in_ready=0 from N.
  - FIN from N to N+1.
  - cpu_hold=0 and load_done=1 from edge N+1.
- With padding, after a program of k words: PAD lasts IMEM_DEPTH-k cycles, then FIN for 1 cycle, then DONE.
- Outside a write cycle, imem_we=0 and imem_wdata holds its last value.
- Reset mid-load returns everything to reset values and wr_ptr to 0. Memory contents are not cleared; the next load overwrites from word 0.
- in_last together with a range error: write the NOP, set err, and terminate normally.

## Configuration
- LOADER_PAD_EN defined: unwritten slots after the last instruction are filled with 0x00000013 before release, so stale memory cannot execute.
- LOADER_PAD_EN undefined: the PAD state is absent; LOAD goes directly to FIN, and memory beyond the program is untouched.

## Test plan
- add x3,x1,x2 → slot 0 = 0x002081B3; sub x5,x3,x4 → slot 1 = 0x404182B3. Sent back-to-back, imem_we is high on two consecutive cycles.
- addi x1,x0,5 → 0x00500093. addi x2,x0,-1 → 0xFFF00113. lw x6,8(x2) → 0x00812303. sw x5,4(x2) → 0x00512223.
- beq x1,x2,-8 with in_last → 0xFE208CE3. cpu_hold falls and load_done rises 1 cycle after the write cycle, with LOADER_PAD_EN undefined.
- addi imm=2048 → NOP written and err=1. beq imm=3 → NOP written. err stays set through DONE.
- IMEM_DEPTH=8, 8 words sent with in_last=0 → err=1, word_count=8, in_ready=0 after the 8th accept. A 9th valid is never accepted.
- LOADER_PAD_EN, IMEM_DEPTH=8, 2-word program → slots 2..7 = 0x00000013 on 6 consecutive cycles, then FIN, then DONE. Reset asserted mid-PAD → all outputs return to reset values.
